// File: rtl/cur_buf_pkg.sv
// Shared types and derived-width helpers for the current-block ping-pong buffer.
package cur_buf_pkg;

    localparam int PASS_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_e;

    function automatic int calc_out_w(input int in_w, input int pack);
        return in_w * pack;
    endfunction

    // Counter/address width with a floor of one bit so degenerate sizes still elaborate.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cur_bank_ram.sv
// Two-bank row store: one write port, one registered read port; bank bit is the address MSB.
module cur_bank_ram #(
    parameter int WIDTH = 64,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW:0]      waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW:0]      raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** (AW + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Synchronous read port; holds its value when no read is issued
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cur_pingpong_buf.sv
// Current-block buffer: packs input words into rows, fills one bank while the
// other bank is replayed REPEAT times to the SAD array.
module cur_pingpong_buf
    import cur_buf_pkg::*;
#(
    parameter  int IN_W   = 32,
    parameter  int PACK   = 2,
    parameter  int ROWS   = 16,
    parameter  int REPEAT = 1,
    parameter  int AW     = calc_aw(ROWS),
    localparam int OUT_W  = calc_out_w(IN_W, PACK)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [AW-1:0]    out_row,
    output logic             out_last,
    output logic             out_blk_last,
    output logic [1:0]       bank_full
);

    localparam int                PCW       = calc_aw(PACK);
    localparam logic [PCW-1:0]    PACK_LAST = PCW'(PACK - 1);
    localparam logic [AW-1:0]     ROW_LAST  = AW'(ROWS - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(REPEAT - 1);

    // Write-side state
    logic [PCW-1:0]    pack_cnt_r;
    logic [OUT_W-1:0]  row_buf_r;
    logic [OUT_W-1:0]  row_merged_s;
    logic [AW-1:0]     wr_row_r;
    logic              wr_bank_r;
    logic [1:0]        bank_full_r;
    logic [1:0]        bank_full_nxt_s;

    // Read-side state
    rd_state_e         state_r;
    rd_state_e         state_nxt_s;
    logic [AW-1:0]     rd_row_r;
    logic [PASS_W-1:0] pass_cnt_r;
    logic              rd_bank_r;
    logic              out_valid_r;
    logic [AW-1:0]     out_row_r;
    logic              out_last_r;
    logic              out_blk_last_r;
    logic              data_vld_r;
    logic [OUT_W-1:0]  ram_rdata_s;

    logic              in_ready_s;
    logic              accept_s;
    logic              row_done_s;
    logic              blk_done_s;
    logic              issue_s;
    logic              final_issue_s;
    logic              release_s;

    assign in_ready_s    = !bank_full_r[wr_bank_r];
    assign accept_s      = in_valid && in_ready_s && !clr;
    assign row_done_s    = accept_s && (pack_cnt_r == PACK_LAST);
    assign blk_done_s    = row_done_s && (wr_row_r == ROW_LAST);
    assign issue_s       = (state_r == ST_READ) && (!out_valid_r || out_ready) && !clr;
    assign final_issue_s = issue_s && (rd_row_r == ROW_LAST) && (pass_cnt_r == PASS_LAST);
    assign release_s     = out_valid_r && out_ready && out_blk_last_r && !clr;

    // Row being assembled with the current lane merged in
    always_comb begin
        row_merged_s = row_buf_r;
        for (int lane = 0; lane < PACK; lane++) begin
            if (pack_cnt_r == PCW'(lane)) begin
                row_merged_s[lane*IN_W +: IN_W] = in_data;
            end else begin
                row_merged_s[lane*IN_W +: IN_W] = row_buf_r[lane*IN_W +: IN_W];
            end
        end
    end

    // Packing counters, row address and write bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_cnt_r <= {PCW{1'b0}};
            row_buf_r  <= {OUT_W{1'b0}};
            wr_row_r   <= {AW{1'b0}};
            wr_bank_r  <= 1'b0;
        end else if (clr) begin
            pack_cnt_r <= {PCW{1'b0}};
            row_buf_r  <= {OUT_W{1'b0}};
            wr_row_r   <= {AW{1'b0}};
            wr_bank_r  <= 1'b0;
        end else if (accept_s) begin
            if (pack_cnt_r == PACK_LAST) begin
                pack_cnt_r <= {PCW{1'b0}};
                wr_row_r   <= (wr_row_r == ROW_LAST) ? {AW{1'b0}} : wr_row_r + 1'b1;
                wr_bank_r  <= blk_done_s ? !wr_bank_r : wr_bank_r;
            end else begin
                pack_cnt_r <= pack_cnt_r + 1'b1;
                row_buf_r  <= row_merged_s;
            end
        end
    end

    // Set on block completion, clear on release; the two always target different banks
    always_comb begin
        bank_full_nxt_s = bank_full_r;
        for (int b = 0; b < 2; b++) begin
            bank_full_nxt_s[b] = (bank_full_r[b] && !(release_s && (rd_bank_r == 1'(b))))
                              || (blk_done_s && (wr_bank_r == 1'(b)));
        end
    end

    // Bank-full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_full_r <= 2'b00;
        end else if (clr) begin
            bank_full_r <= 2'b00;
        end else begin
            bank_full_r <= bank_full_nxt_s;
        end
    end

    // Read FSM next state; a released-but-unacknowledged block keeps IDLE from re-entering READ
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bank_full_r[rd_bank_r] && !(out_valid_r && out_blk_last_r)) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (final_issue_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read row, pass counter and read bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_row_r   <= {AW{1'b0}};
            pass_cnt_r <= {PASS_W{1'b0}};
            rd_bank_r  <= 1'b0;
        end else if (clr) begin
            rd_row_r   <= {AW{1'b0}};
            pass_cnt_r <= {PASS_W{1'b0}};
            rd_bank_r  <= 1'b0;
        end else begin
            if (issue_s) begin
                rd_row_r <= (rd_row_r == ROW_LAST) ? {AW{1'b0}} : rd_row_r + 1'b1;
            end
            if (release_s) begin
                pass_cnt_r <= {PASS_W{1'b0}};
                rd_bank_r  <= !rd_bank_r;
            end else if (issue_s && (rd_row_r == ROW_LAST)) begin
                pass_cnt_r <= pass_cnt_r + 1'b1;
            end
        end
    end

    // Output beat registers, aligned with the synchronous memory read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_row_r      <= {AW{1'b0}};
            out_last_r     <= 1'b0;
            out_blk_last_r <= 1'b0;
            data_vld_r     <= 1'b0;
        end else if (clr) begin
            out_valid_r    <= 1'b0;
            out_row_r      <= {AW{1'b0}};
            out_last_r     <= 1'b0;
            out_blk_last_r <= 1'b0;
            data_vld_r     <= 1'b0;
        end else if (issue_s) begin
            out_valid_r    <= 1'b1;
            out_row_r      <= rd_row_r;
            out_last_r     <= (rd_row_r == ROW_LAST);
            out_blk_last_r <= final_issue_s;
            data_vld_r     <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_valid_r    <= 1'b0;
        end
    end

    cur_bank_ram #(
        .WIDTH (OUT_W),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (row_done_s),
        .waddr ({wr_bank_r, wr_row_r}),
        .wdata (row_merged_s),
        .re    (issue_s),
        .raddr ({rd_bank_r, rd_row_r}),
        .rdata (ram_rdata_s)
    );

    // The memory has no reset, so its read register is masked until the first read after reset/clr
    assign out_data     = data_vld_r ? ram_rdata_s : {OUT_W{1'b0}};
    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_row      = out_row_r;
    assign out_last     = out_last_r;
    assign out_blk_last = out_blk_last_r;
    assign bank_full    = bank_full_r;

endmodule

// File: tb/tb_cur_pingpong_buf.sv
// Directed scoreboard bench: default instance A and a PACK=4/ROWS=8/REPEAT=3 instance B.
module tb_cur_pingpong_buf;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  row;
        logic        last;
        logic        blk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        sel_t;
    logic        in_valid_t;
    logic [31:0] in_data_t;
    logic        out_ready_t;
    logic        rand_mode;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_last, a_out_blk_last;
    logic [31:0] a_in_data;
    logic [63:0] a_out_data;
    logic [3:0]  a_out_row;
    logic [1:0]  a_bank_full;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_blk_last;
    logic [15:0] b_in_data;
    logic [63:0] b_out_data;
    logic [2:0]  b_out_row;
    logic [1:0]  b_bank_full;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] wbuf[64];
    int          wcnt;
    int          total;
    int          bad;
    int          popped[2];
    logic        stall_v[2];
    logic [63:0] stall_d[2];
    logic [3:0]  stall_row[2];

    assign a_in_valid = in_valid_t && !sel_t;
    assign b_in_valid = in_valid_t && sel_t;
    assign a_in_data  = in_data_t;
    assign b_in_data  = in_data_t[15:0];

    always #5 clk = ~clk;

    cur_pingpong_buf u_a (
        .clk (clk), .rst_n (rst_n), .clr (clr),
        .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
        .out_valid (a_out_valid), .out_ready (out_ready_t), .out_data (a_out_data),
        .out_row (a_out_row), .out_last (a_out_last), .out_blk_last (a_out_blk_last),
        .bank_full (a_bank_full)
    );

    cur_pingpong_buf #(.IN_W (16), .PACK (4), .ROWS (8), .REPEAT (3)) u_b (
        .clk (clk), .rst_n (rst_n), .clr (clr),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
        .out_valid (b_out_valid), .out_ready (out_ready_t), .out_data (b_out_data),
        .out_row (b_out_row), .out_last (b_out_last), .out_blk_last (b_out_blk_last),
        .bank_full (b_bank_full)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready_t = 1'($urandom_range(0, 1));
    endtask

    // Expected rows of one complete block for the selected instance
    task automatic push_block(input logic s);
        int pk, rw, rp, iw;
        exp_t e;
        logic [63:0] m;
        pk = s ? 4 : 2;
        rw = s ? 8 : 16;
        rp = s ? 3 : 1;
        iw = s ? 16 : 32;
        m  = (64'd1 << iw) - 64'd1;
        for (int p = 0; p < rp; p++) begin
            for (int r = 0; r < rw; r++) begin
                e.data = 64'd0;
                for (int l = 0; l < pk; l++) begin
                    e.data = e.data | ((64'(wbuf[r*pk+l]) & m) << (l * iw));
                end
                e.row  = 4'(r);
                e.last = (r == rw - 1);
                e.blk  = e.last && (p == rp - 1);
                if (s) qb.push_back(e);
                else   qa.push_back(e);
            end
        end
    endtask

    task automatic feed(input logic [31:0] w);
        int g;
        logic rdy;
        g = 0;
        in_valid_t = 1'b1;
        in_data_t  = w;
        rdy = sel_t ? b_in_ready : a_in_ready;
        while (!rdy && g < 2000) begin
            tick();
            g++;
            rdy = sel_t ? b_in_ready : a_in_ready;
        end
        check("feed_timeout", 64'(rdy), 64'd1);
        tick();
        in_valid_t = 1'b0;
        if (rdy) begin
            wbuf[wcnt] = sel_t ? {16'd0, w[15:0]} : w;
            wcnt++;
            if (wcnt == (sel_t ? 32 : 32)) begin
                push_block(sel_t);
                wcnt = 0;
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_out_valid || b_out_valid) && g < 4000) begin
            tick();
            g++;
        end
        check("drain_timeout", 64'(g < 4000), 64'd1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        qa.delete();
        qb.delete();
        wcnt = 0;
        tick();
        clr = 1'b0;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_in_ready"},  64'(a_in_ready),     64'd1);
        check({tag, "_out_valid"}, 64'(a_out_valid),    64'd0);
        check({tag, "_out_data"},  a_out_data,          64'd0);
        check({tag, "_out_row"},   64'(a_out_row),      64'd0);
        check({tag, "_out_last"},  64'(a_out_last),     64'd0);
        check({tag, "_blk_last"},  64'(a_out_blk_last), 64'd0);
        check({tag, "_bank_full"}, 64'(a_bank_full),    64'd0);
    endtask

    task automatic mon_step(input int s, input logic v, input logic [63:0] d,
                            input logic [3:0] row, input logic l, input logic bl);
        exp_t e;
        int sz;
        if (stall_v[s]) begin
            check("stall_valid", 64'(v), 64'd1);
            check("stall_data", d, stall_d[s]);
            check("stall_row", 64'(row), 64'(stall_row[s]));
        end
        if (v && out_ready_t) begin
            sz = (s == 1) ? qb.size() : qa.size();
            check("beat_expected", 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                e = (s == 1) ? qb.pop_front() : qa.pop_front();
                check(s ? "b_data" : "a_data", d, e.data);
                check(s ? "b_row" : "a_row", 64'(row), 64'(e.row));
                check(s ? "b_last" : "a_last", 64'(l), 64'(e.last));
                check(s ? "b_blk_last" : "a_blk_last", 64'(bl), 64'(e.blk));
            end
            popped[s]++;
        end
        stall_v[s]   = v && !out_ready_t;
        stall_d[s]   = d;
        stall_row[s] = row;
    endtask

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n || clr) begin
            stall_v[0] = 1'b0;
            stall_v[1] = 1'b0;
        end else begin
            mon_step(0, a_out_valid, a_out_data, a_out_row, a_out_last, a_out_blk_last);
            mon_step(1, b_out_valid, b_out_data, {1'b0, b_out_row}, b_out_last, b_out_blk_last);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, base;
        logic found;
        total = 0; bad = 0; wcnt = 0;
        popped[0] = 0; popped[1] = 0;
        stall_v[0] = 1'b0; stall_v[1] = 1'b0;
        rst_n = 1'b0; clr = 1'b0; sel_t = 1'b0; in_valid_t = 1'b0;
        in_data_t = 32'd0; out_ready_t = 1'b1; rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_a_reset("rst");
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_bank_full", 64'(b_bank_full), 64'd0);

        // One block back-to-back, full throughput
        for (int i = 0; i < 32; i++) feed(32'(i));
        drain();
        check("t1_popped", 64'(popped[0]), 64'd16);
        check("t1_bank_full", 64'(a_bank_full), 64'd0);

        // Fill both banks with the output stalled
        pulse_clr();
        out_ready_t = 1'b0;
        for (int i = 0; i < 64; i++) feed(32'h1000 + 32'(i));
        check("t2_bank_full", 64'(a_bank_full), 64'd3);
        check("t2_in_ready", 64'(a_in_ready), 64'd0);
        in_valid_t = 1'b1;
        in_data_t  = 32'd64;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_in_ready", 64'(a_in_ready), 64'd0);
            tick();
        end
        in_valid_t  = 1'b0;
        out_ready_t = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (a_out_valid && a_out_blk_last) found = 1'b1;
        end
        check("t2_blk_last_seen", 64'(found), 64'd1);
        check("t2_ready_before_release", 64'(a_in_ready), 64'd0);
        tick();
        check("t2_ready_after_release", 64'(a_in_ready), 64'd1);
        check("t2_bank_full_after", 64'(a_bank_full), 64'd2);
        drain();

        // Continuous stream of four blocks with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 128; i++) feed($urandom);
        drain();
        rand_mode   = 1'b0;
        out_ready_t = 1'b1;
        check("t4_bank_full", 64'(a_bank_full), 64'd0);

        // clr in the middle of a fill, then a clean block
        for (int i = 0; i < 9; i++) feed(32'hdead_0000 + 32'(i));
        pulse_clr();
        check_a_reset("clr_fill");
        for (int i = 0; i < 32; i++) feed(32'd100 + 32'(i));
        drain();

        // clr while row 5 is presented, then a clean block
        pulse_clr();
        for (int i = 0; i < 32; i++) feed(32'h5a00 + 32'(i));
        base = popped[0];
        g = 0;
        while (popped[0] < base + 5 && g < 500) begin
            tick();
            g++;
        end
        check("t6_row5_reached", 64'(a_out_row), 64'd5);
        pulse_clr();
        check_a_reset("clr_read");
        for (int i = 0; i < 32; i++) feed(32'h7700 + 32'(i));
        drain();

        // Instance B: four words per row, eight rows, three passes
        sel_t = 1'b1;
        base  = popped[1];
        for (int i = 0; i < 32; i++) feed(32'(i));
        drain();
        check("b_popped", 64'(popped[1] - base), 64'd24);
        check("b_bank_full", 64'(b_bank_full), 64'd0);

        check("end_qa_empty", 64'(qa.size()), 64'd0);
        check("end_qb_empty", 64'(qb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cur_pingpong_buf.md
Name: cur_pingpong_buf

Overview:
- Parametrised current-block buffer for the motion-estimation datapath.
- Accepts a stream of IN_W-bit pixel words and packs PACK words into one OUT_W-bit row.
- Stores each ROWS-row current block in one half of a ping-pong memory.
- Replays every stored block REPEAT times to the SAD array while the other bank fills.

Parameters:
IN_W, 32, input word width in bits
PACK, 2, input words per stored row; OUT_W = IN_W*PACK
ROWS, 16, rows per current block (power of two, >=2)
REPEAT, 1, number of full read passes per block before the bank is released (1..255)
AW, $clog2(ROWS), row address width (derived; do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; same effect as reset, one cycle
in_valid  in  1  input word valid
in_ready  out  1  input word may be accepted
in_data  in  IN_W  input pixel word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  OUT_W  packed row; lane 0 (first word received) in bits [IN_W-1:0]
out_row  out  AW  row index of out_data
out_last  out  1  last row of the current pass
out_blk_last  out  1  last row of the last pass; the bank is released on this transfer
bank_full  out  2  per-bank full flags

Behaviour:
- Reset/clr: all counters 0, wr_bank=0, rd_bank=0, bank_full=00, out_valid=0, out_data=0, out_row=0, out_last=0, out_blk_last=0.
- Reset/clr: in_ready=1 on the first cycle after reset or clr.
- An in-flight block is discarded by reset or clr; memory contents need not be cleared.
- Write side:
  - in_ready = !bank_full[wr_bank]; a word is accepted when in_valid && in_ready.
  - pack_cnt (0..PACK-1) selects the lane of a row register. The accepted lane is written in that cycle.
  - On the accept with pack_cnt==PACK-1, the completed row (with this lane merged) is written to memory at {wr_bank,wr_row} in the same clock edge.
  - pack_cnt then wraps to 0 and wr_row increments.
  - When wr_row==ROWS-1 completes: bank_full[wr_bank] is set, wr_bank toggles, and wr_row wraps to 0.
  - in_ready therefore drops the next cycle only if the other bank is still full.
- Read side: FSM with states IDLE and READ.
  - IDLE -> READ when bank_full[rd_bank]=1.
  - In READ, a row read is issued when !out_valid || out_ready. The memory read is synchronous: data, out_row, out_last and out_blk_last register one cycle after issue, and out_valid is set then.
  - If out_valid && !out_ready, all out_* outputs hold and no read is issued. Full throughput is one row per cycle with out_ready held high.
  - rd_row increments per issue; on ROWS-1 it wraps and pass_cnt increments.
  - The issue with rd_row==ROWS-1 and pass_cnt==REPEAT-1 is the final issue. After it the FSM returns to IDLE and issues nothing more for this bank.
  - Release happens on the handshake of the out_blk_last beat: bank_full[rd_bank] clears, rd_bank toggles, pass_cnt=0.
  - The FSM may re-enter READ on the cycle after release.
- out_valid drops when the final beat is accepted and no new issue occurs.
- Simultaneous events:
  - The set of bank_full[wr_bank] and the clear of bank_full[rd_bank] in the same cycle target different banks, and both take effect.
  - A write into the bank being read is impossible by construction.
  - clr has priority over all handshakes.
- Counter widths: pack_cnt $clog2(PACK) (min 1), pass_cnt 8 bits. No arithmetic overflow is possible within the legal parameter ranges.

Decomposition:
- Package cur_buf_pkg holds: FSM state enum (IDLE, READ), the derived OUT_W/AW helper functions, and the REPEAT counter width constant.
- One sub-module: cur_bank_ram, a simple dual-port memory (1 write port, 1 synchronous read port) of depth 2*ROWS and width OUT_W.
  - Bank bit is the address MSB.
  - Behavioural flop array here; the SRAM macro is swapped in behind the same ports.

Test Plan:
- Defaults, feed words 0..31 back-to-back, out_ready=1 -> 16 rows out, row k = {2k+1,2k}, out_last and out_blk_last on row 15, bank_full returns to 00.
- Feed 64 words with out_ready=0 -> bank_full=11 after word 63, in_ready=0, word 64 held off.
  - Then raise out_ready -> bank 0 drains, in_ready=1 the cycle after its out_blk_last handshake.
- REPEAT=3, one block -> 48 beats, row sequence 0..15 three times, out_last at beats 15/31/47, out_blk_last only at beat 47.
- Random out_ready toggling (50%) with a continuous input stream of 4 blocks -> no duplicated or dropped rows, out_data stable while out_valid&&!out_ready.
- PACK=4, IN_W=16, ROWS=8 -> row k = {4k+3,4k+2,4k+1,4k}.
- Assert clr mid-fill (word 9) and separately mid-read (row 5) -> all outputs at reset values next cycle; the next block fed reads back correctly from bank 0, row 0.
